// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the execute stage and mem_access_unit.
// master drives the request; slave returns load data and status.
interface mem_access_unit_if;
  logic        Start;
  logic [2:0]  MemOp;
  logic [6:0]  Addr;
  logic [31:0] StoreData;
  logic [31:0] LoadData;
  logic        Busy;
  logic        Done;
  logic        AddrErr;

  modport master (
    output Start, MemOp, Addr, StoreData,
    input  LoadData, Busy, Done, AddrErr
  );

  modport slave (
    input  Start, MemOp, Addr, StoreData,
    output LoadData, Busy, Done, AddrErr
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store sequencer for the 32-word DataRAM: word-granular access,
// read-modify-write for SB/SH, sign/zero-extended loads.
module mem_access_unit (
  input  logic             Clk,
  input  logic             Reset,
  mem_access_unit_if.slave bus,
  output logic [4:0]       RamAddr,
  output logic [31:0]      RamDataIn,
  output logic             RamWr,
  input  logic [31:0]      RamDataOut
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [31:0] load_q;
  logic        err_q;

  logic        misaligned;
  logic        is_load;
  logic [4:0]  shamt;
  logic [31:0] lane, load_ext;
  logic [31:0] mask, wdata, merged;

  always_comb begin
    misaligned = 1'b0;
    case (bus.MemOp)
      OP_LW, OP_SW:         misaligned = |bus.Addr[1:0];
      OP_LH, OP_LHU, OP_SH: misaligned = bus.Addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign is_load = (op_q < OP_SW);
  assign shamt   = {lane_q, 3'b000};
  assign lane    = RamDataOut >> shamt;

  always_comb begin
    load_ext = RamDataOut;
    case (op_q)
      OP_LB:   load_ext = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  load_ext = {24'h0, lane[7:0]};
      OP_LH:   load_ext = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  load_ext = {16'h0, lane[15:0]};
      default: load_ext = RamDataOut;
    endcase
  end

  // RamDataIn still holds the latched store operand during READ
  always_comb begin
    mask   = 32'h0000_FFFF << shamt;
    wdata  = {2{RamDataIn[15:0]}};
    if (op_q == OP_SB) begin
      mask  = 32'h0000_00FF << shamt;
      wdata = {4{RamDataIn[7:0]}};
    end
    merged = (RamDataOut & ~mask) | (wdata & mask);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          if (misaligned)               state_nxt = DONE;
          else if (bus.MemOp == OP_SW)  state_nxt = WRITE;
          else                          state_nxt = READ;
        end
      end
      READ:    state_nxt = is_load ? DONE : WRITE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q      <= OP_LW;
      lane_q    <= 2'b00;
      load_q    <= 32'h0;
      err_q     <= 1'b0;
      RamAddr   <= 5'h0;
      RamDataIn <= 32'h0;
    end else begin
      if (state == IDLE && bus.Start) begin
        op_q      <= bus.MemOp;
        lane_q    <= bus.Addr[1:0];
        err_q     <= misaligned;
        RamAddr   <= bus.Addr[6:2];
        RamDataIn <= bus.StoreData;
      end
      if (state == READ) begin
        if (is_load) load_q    <= load_ext;
        else         RamDataIn <= merged;
      end
    end
  end

  assign bus.Busy     = (state != IDLE);
  assign bus.Done     = (state == DONE);
  assign bus.AddrErr  = err_q;
  assign bus.LoadData = load_q;
  assign RamWr        = (state == WRITE) & ~Reset;

endmodule
